// File: rtl/gate_bist_if.sv
// Handshake and result bundle between the BIST sequencer and its primitive under test.
// start/abort are single-cycle request levels sampled on the rising clock edge.
interface gate_bist_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic            abort;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN-1:0] fail_vec;
    logic [N_IN:0]   fail_count;

    modport slave (
        input  start, abort, dut_out,
        output dut_in, busy, done, pass, fail_vec, fail_count
    );

    modport master (
        output start, abort, dut_out,
        input  dut_in, busy, done, pass, fail_vec, fail_count
    );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Exhaustive self-test sequencer for one N-input combinational primitive:
// applies every vector, waits SETTLE cycles, and compares against a truth table.
module gate_bist_ctrl #(
    parameter int                  N_IN   = 2,
    parameter logic [2**N_IN-1:0]  TRUTH  = 4'b0111,
    parameter int                  SETTLE = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    gate_bist_if.slave   bus,
    output logic [2:0]   dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN:0]     LAST_VEC = (N_IN+1)'(2**N_IN - 1);

    state_t          state_q, state_d;
    logic [N_IN:0]   vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic [N_IN:0]   fail_count_q, fail_count_d;
    logic [N_IN-1:0] fail_vec_q, fail_vec_d;

    logic            running;
    logic            exp_bit;
    logic            mismatch;
    logic [N_IN:0]   vec_next;

    assign running  = (state_q == APPLY) || (state_q == WAIT) || (state_q == CHECK);
    assign exp_bit  = TRUTH[vec_q[N_IN-1:0]];
    // Case inequality so an X/Z response from the primitive is treated as a failure.
    assign mismatch = (bus.dut_out !== exp_bit);
    assign vec_next = vec_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            dut_in_q     <= '0;
            fail_count_q <= '0;
            fail_vec_q   <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            dut_in_q     <= dut_in_d;
            fail_count_q <= fail_count_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        dut_in_d     = dut_in_q;
        fail_count_d = fail_count_q;
        fail_vec_d   = fail_vec_q;

        if (running && bus.abort) begin
            // Partial results survive an abort; only the drive and status drop.
            state_d  = IDLE;
            dut_in_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d      = APPLY;
                        vec_d        = '0;
                        dut_in_d     = '0;
                        fail_count_d = '0;
                        fail_vec_d   = '0;
                    end
                end
                APPLY: begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) state_d = CHECK;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_count_d = fail_count_q + 1'b1;
                        if (fail_count_q == '0) fail_vec_d = vec_q[N_IN-1:0];
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                    end else begin
                        vec_d    = vec_next;
                        dut_in_d = vec_next[N_IN-1:0];
                        state_d  = APPLY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.dut_in     = dut_in_q;
    assign bus.busy       = running;
    assign bus.done       = (state_q == DONE);
    assign bus.pass       = (state_q == DONE) && (fail_count_q == '0);
    assign bus.fail_vec   = fail_vec_q;
    assign bus.fail_count = fail_count_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl wrapped around a behavioural 2-input NAND
// whose output can be forced, stuck, or made unknown on one vector.
module tb_gate_bist_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;
    int         mode;
    int         checks;
    int         errors;

    gate_bist_if #(.N_IN(2)) bus ();

    gate_bist_ctrl #(.N_IN(2), .TRUTH(4'b0111), .SETTLE(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0 good NAND, 1 output forced 1, 2 stuck 0, 3 X on vector 1 only
    always_comb begin
        case (mode)
            1:       bus.dut_out = 1'b1;
            2:       bus.dut_out = 1'b0;
            3:       bus.dut_out = (bus.dut_in == 2'b01) ? 1'bx : ~&bus.dut_in;
            default: bus.dut_out = ~&bus.dut_in;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    // Starts a run and follows it to DONE; accept edge is edge 0.
    task automatic run_and_check(input string name, input bit poke, input logic exp_pass,
                                 input logic [2:0] exp_fc, input logic [1:0] exp_fv);
        int edges;
        bit seen;
        logic [1:0] exp_in;
        pulse_start();
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.dut_in !== 2'b00) begin
            errors++;
            $display("FAIL %s_accept: busy=%b done=%b dut_in=%b, want 1 0 00",
                     name, bus.busy, bus.done, bus.dut_in);
        end
        edges = 0;
        seen  = 1'b0;
        for (int n = 1; n <= 60 && !seen; n++) begin
            @(posedge clk); #1;
            bus.start = poke && (n == 5 || n == 12);
            if (n % 7 == 3) begin
                exp_in = 2'(n / 7);
                checks++;
                if (bus.dut_in !== exp_in) begin
                    errors++;
                    $display("FAIL %s_dut_in@%0d: got %b want %b", name, n, bus.dut_in, exp_in);
                end
            end
            if (bus.done === 1'b1) begin
                seen  = 1'b1;
                edges = n;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (edges != 28) begin
            errors++;
            $display("FAIL %s_done_edge: got %0d want 28 (0 = timeout)", name, edges);
        end
        checks++;
        if (bus.pass !== exp_pass || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_pass: pass=%b busy=%b, want %b 0", name, bus.pass, bus.busy, exp_pass);
        end
        checks++;
        if (bus.fail_count !== exp_fc) begin
            errors++;
            $display("FAIL %s_fail_count: got %0d want %0d", name, bus.fail_count, exp_fc);
        end
        if (exp_fc != 3'd0) begin
            checks++;
            if (bus.fail_vec !== exp_fv) begin
                errors++;
                $display("FAIL %s_fail_vec: got %b want %b", name, bus.fail_vec, exp_fv);
            end
        end
        checks++;
        if (bus.dut_in !== 2'b11 || dbg_state !== 3'd4) begin
            errors++;
            $display("FAIL %s_done_hold: dut_in=%b state=%0d, want 11 4", name, bus.dut_in, dbg_state);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; mode = 0;
        #12;
        checks++;
        if (bus.busy !== 0 || bus.done !== 0 || bus.pass !== 0 || bus.dut_in !== 0 ||
            bus.fail_vec !== 0 || bus.fail_count !== 0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b pass=%b dut_in=%b fv=%b fc=%0d st=%0d, want all 0",
                     bus.busy, bus.done, bus.pass, bus.dut_in, bus.fail_vec, bus.fail_count, dbg_state);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_good_gate();
        mode = 0;
        run_and_check("good", 1'b0, 1'b1, 3'd0, 2'b00);
    endtask

    task automatic test_forced_one();
        mode = 1;
        run_and_check("force1", 1'b0, 1'b0, 3'd1, 2'b11);
    endtask

    task automatic test_stuck_zero_rerun();
        mode = 2;
        run_and_check("stuck0", 1'b0, 1'b0, 3'd3, 2'b00);
        run_and_check("stuck0_rerun", 1'b0, 1'b0, 3'd3, 2'b00);
    endtask

    task automatic test_x_output();
        mode = 3;
        run_and_check("xout", 1'b0, 1'b0, 3'd1, 2'b01);
    endtask

    task automatic test_idle_done_controls();
        mode = 0;
        // abort in DONE is ignored
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_done: done=%b busy=%b, want 1 0", bus.done, bus.busy);
        end
        // start and abort together in DONE: start wins
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || dbg_state !== 3'd1) begin
            errors++;
            $display("FAIL start_abort_in_done: busy=%b done=%b st=%0d, want 1 0 1",
                     bus.busy, bus.done, dbg_state);
        end
        // abort on the next edge wins over the running run
        bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL abort_in_apply: busy=%b st=%0d, want 0 0", bus.busy, dbg_state);
        end
    endtask

    task automatic test_abort();
        mode = 2;
        pulse_start();
        repeat (17) @(posedge clk);
        #1;
        checks++;
        if (dbg_state !== 3'd2 || bus.dut_in !== 2'b10) begin
            errors++;
            $display("FAIL abort_pre: st=%0d dut_in=%b, want 2 10", dbg_state, bus.dut_in);
        end
        bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 0 || bus.done !== 0 || bus.dut_in !== 2'b00 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b dut_in=%b st=%0d, want 0 0 00 0",
                     bus.busy, bus.done, bus.dut_in, dbg_state);
        end
        checks++;
        if (bus.fail_count !== 3'd2 || bus.fail_vec !== 2'b00) begin
            errors++;
            $display("FAIL abort_partial: fc=%0d fv=%b, want 2 00", bus.fail_count, bus.fail_vec);
        end
        // abort in IDLE is ignored too
        bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        checks++;
        if (dbg_state !== 3'd0 || bus.fail_count !== 3'd2) begin
            errors++;
            $display("FAIL abort_in_idle: st=%0d fc=%0d, want 0 2", dbg_state, bus.fail_count);
        end
    endtask

    task automatic test_start_while_busy();
        mode = 0;
        run_and_check("busy_start", 1'b1, 1'b1, 3'd0, 2'b00);
    endtask

    task automatic test_async_reset();
        mode = 2;
        pulse_start();
        repeat (24) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 0 || bus.done !== 0 || bus.pass !== 0 || bus.dut_in !== 0 ||
            bus.fail_vec !== 0 || bus.fail_count !== 0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b pass=%b dut_in=%b fv=%b fc=%0d st=%0d, want all 0",
                     bus.busy, bus.done, bus.pass, bus.dut_in, bus.fail_vec, bus.fail_count, dbg_state);
        end
        @(negedge clk); rst_n = 1'b1;
        mode = 0;
        run_and_check("post_reset", 1'b0, 1'b1, 3'd0, 2'b00);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_good_gate();
        test_forced_one();
        test_stuck_zero_rerun();
        test_x_output();
        test_idle_done_controls();
        test_abort();
        test_start_while_busy();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
